// File: rtl/alu_exec_unit.sv
// Execute unit: NREGS x WIDTH register file fused with an 8-op ALU behind a valid/ready handshake.
// Single-cycle ops retire on the accept edge; MUL iterates WIDTH shift-add steps before writeback.
module alu_exec_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [2:0]                 OP,
  input  logic [$clog2(NREGS)-1:0]   RS1,
  input  logic [$clog2(NREGS)-1:0]   RS2,
  input  logic                       IMM_EN,
  input  logic [WIDTH-1:0]           IMM,
  input  logic [$clog2(NREGS)-1:0]   RD,
  output logic                       OUT_VALID,
  output logic [$clog2(NREGS)-1:0]   OUT_RD,
  output logic [WIDTH-1:0]           OUT_Y,
  output logic                       BUSY,
  input  logic [$clog2(NREGS)-1:0]   DBG_A,
  output logic [WIDTH-1:0]           DBG_RD
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    mul_rd_q, mul_rd_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;

  logic [WIDTH-1:0] op_a, op_b, alu_y, acc_step;
  logic [SW-1:0]    shamt;
  logic             accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  function automatic logic [WIDTH-1:0] read_reg(input logic [AW-1:0] addr);
    if (ZERO_REG != 0 && addr == '0) return '0;
    return regs_q[addr];
  endfunction

  always_comb begin
    IN_READY  = (state_q == S_IDLE) && !RST;
    BUSY      = (state_q == S_MUL);
    OUT_VALID = out_valid_q;
    OUT_RD    = out_rd_q;
    OUT_Y     = out_y_q;
    DBG_RD    = read_reg(DBG_A);
    accept    = IN_VALID && IN_READY;
    op_a      = read_reg(RS1);
    op_b      = IMM_EN ? IMM : read_reg(RS2);
    shamt     = op_b[SW-1:0];
  end

  always_comb begin
    alu_y = '0;
    case (OP)
      3'b000: alu_y = op_a + op_b;
      3'b001: alu_y = op_a - op_b;
      3'b010: alu_y = op_a << shamt;
      3'b011: alu_y = op_a >> shamt;
      3'b100: alu_y = $signed(op_a) >>> shamt;
      3'b101: alu_y = op_a & op_b;
      3'b110: alu_y = op_a ^ op_b;
      default: alu_y = '0;
    endcase
  end

  // One multiplier bit per cycle; the final step's sum is written back directly.
  always_comb begin
    acc_step = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0);
  end

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_rd_d    = mul_rd_q;
    out_valid_d = 1'b0;
    out_rd_d    = out_rd_q;
    out_y_d     = out_y_q;
    wr_en       = 1'b0;
    wr_addr     = RD;
    wr_data     = alu_y;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (OP == 3'b111) begin
            state_d  = S_MUL;
            mul_a_d  = op_a;
            mul_b_d  = op_b;
            mul_rd_d = RD;
            cnt_d    = '0;
            acc_d    = '0;
          end else begin
            wr_en       = 1'b1;
            out_valid_d = 1'b1;
            out_rd_d    = RD;
            out_y_d     = alu_y;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          wr_en       = 1'b1;
          wr_addr     = mul_rd_q;
          wr_data     = acc_step;
          out_valid_d = 1'b1;
          out_rd_d    = mul_rd_q;
          out_y_d     = acc_step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_rd_q    <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_rd_q    <= mul_rd_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_y_q     <= out_y_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end
endmodule
